// File: rtl/rot_stream_ctrl.sv
// Purpose: two-stage streaming wrapper around the external 8-bit right-rotator, with per-byte fixed or auto-incrementing amount and a transfer counter.
// Latency: a byte accepted at edge N is presented on o_data/o_valid after edge N+1; full throughput of one byte per cycle.
// Backpressure: o_ready falls when both stages hold data and the consumer stalls; stalled stages hold, so no byte is lost or duplicated.
module rot_stream_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_mode,
    input  logic [2:0]       i_k_cfg,
    input  logic [7:0]       i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [7:0]       o_rot_a,
    output logic [2:0]       o_rot_k,
    input  logic [7:0]       i_rot_y,
    output logic [7:0]       o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Stage-1 holding register feeding the rotator.
    logic       s1_valid;
    logic [7:0] s1_data;
    logic [2:0] s1_k;

    // Running rotate amount used when a byte arrives in auto-increment mode.
    logic [2:0] k_cnt;

    // Pipeline advance controls.
    logic en1;
    logic en2;
    logic accept;
    logic xfer;

    // Stage 2 can load whenever it is empty or the consumer drains it; stage 1
    // can load whenever it is empty or its content moves into stage 2. The
    // i_ready -> o_ready combinational path is intentional: it keeps the
    // pipeline at one byte per cycle without a skid buffer.
    always_comb begin
        en2     = ~o_valid | i_ready;
        en1     = ~s1_valid | en2;
        o_ready = en1 & ~i_rst & ~i_clear;
        accept  = i_valid & o_ready;
        // A transfer during clear is not counted; o_ready already blocks
        // accepts during clear and reset.
        xfer    = o_valid & i_ready & ~i_rst & ~i_clear;
    end

    // The rotator sees the registered stage-1 byte and amount directly, so
    // its inputs stay stable (last value) while stage 1 is empty.
    assign o_rot_a = s1_data;
    assign o_rot_k = s1_k;

    // Stage-1 register: load on accept, drain when it advances with nothing new.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_data  <= 8'h00;
            s1_k     <= 3'd0;
        end else if (i_clear) begin
            // Flush drops the in-flight byte but leaves the rotator inputs as they are.
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_data  <= i_data;
            s1_k     <= i_mode ? k_cnt : i_k_cfg;
        end else if (en1) begin
            s1_valid <= 1'b0;
        end
    end

    // Auto-increment amount: advances only on bytes accepted in mode 1, wraps mod 8.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            k_cnt <= 3'd0;
        end else if (i_clear) begin
            k_cnt <= i_k_cfg;
        end else if (accept && i_mode) begin
            k_cnt <= k_cnt + 3'd1;
        end
    end

    // Stage-2 output register: capture the rotator result when stage 2 advances.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_data  <= 8'h00;
        end else if (i_clear) begin
            // o_data keeps its last value; only the valid flag is flushed.
            o_valid <= 1'b0;
        end else if (en2) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_data <= i_rot_y;
            end
        end
    end

    // Saturating count of completed output handshakes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_cnt <= '0;
        end else if (i_clear) begin
            o_cnt <= '0;
        end else if (xfer && (o_cnt != CNT_MAX)) begin
            o_cnt <= o_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rot_stream_ctrl.sv
// Purpose: directed self-checking bench for rot_stream_ctrl, with a behavioural rotator closing the loop.
// Latency: checks o_data/o_valid one edge after the accepting edge.
// Backpressure: drives i_ready low to stall and checks hold/order/count behaviour.
module tb_rot_stream_ctrl;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        mode;
    logic [2:0]  k_cfg;
    logic [7:0]  din;
    logic        din_vld;
    logic        cons_rdy;

    logic        dut_rdy;
    logic [7:0]  rot_a;
    logic [2:0]  rot_k;
    logic [7:0]  rot_y;
    logic [7:0]  dout;
    logic        dout_vld;
    logic [15:0] cnt;

    logic        dut4_rdy;
    logic [7:0]  rot4_a;
    logic [2:0]  rot4_k;
    logic [7:0]  rot4_y;
    logic [7:0]  dout4;
    logic        dout4_vld;
    logic [3:0]  cnt4;

    int tests;
    int fails;
    logic [7:0] exp_seq [9];

    // Reference rotator: y[i] = a[(i+k)%8], i.e. rotate right by k.
    function automatic logic [7:0] rotr(input logic [7:0] a, input logic [2:0] k);
        logic [15:0] t;
        t = {a, a} >> k;
        return t[7:0];
    endfunction

    assign rot_y  = rotr(rot_a, rot_k);
    assign rot4_y = rotr(rot4_a, rot4_k);

    rot_stream_ctrl #(.CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_mode(mode), .i_k_cfg(k_cfg),
        .i_data(din), .i_valid(din_vld), .o_ready(dut_rdy),
        .o_rot_a(rot_a), .o_rot_k(rot_k), .i_rot_y(rot_y),
        .o_data(dout), .o_valid(dout_vld), .i_ready(cons_rdy), .o_cnt(cnt)
    );

    rot_stream_ctrl #(.CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_mode(mode), .i_k_cfg(k_cfg),
        .i_data(din), .i_valid(din_vld), .o_ready(dut4_rdy),
        .o_rot_a(rot4_a), .o_rot_k(rot4_k), .i_rot_y(rot4_y),
        .o_data(dout4), .o_valid(dout4_vld), .i_ready(cons_rdy), .o_cnt(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle a little after it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; clear = 1'b0; mode = 1'b0; k_cfg = 3'd0;
        din = 8'h00; din_vld = 1'b0; cons_rdy = 1'b0;

        // ---- Reset state ----
        tick();
        tick();
        chk("rst_o_valid", 32'(dout_vld), 32'h0);
        chk("rst_o_data",  32'(dout),     32'h0);
        chk("rst_o_rot_a", 32'(rot_a),    32'h0);
        chk("rst_o_rot_k", 32'(rot_k),    32'h0);
        chk("rst_o_cnt",   32'(cnt),      32'h0);
        chk("rst_o_ready", 32'(dut_rdy),  32'h0);

        // ---- Fixed mode, k=1: 0x81 -> 0xC0 ----
        rst = 1'b0; mode = 1'b0; k_cfg = 3'd1; cons_rdy = 1'b1;
        din = 8'h81; din_vld = 1'b1;
        #1 chk("fix_o_ready", 32'(dut_rdy), 32'h1);
        tick();                                   // edge N: accept
        din_vld = 1'b0;
        chk("fix_rot_k", 32'(rot_k), 32'h1);
        tick();                                   // edge N+1: present
        chk("fix_o_valid", 32'(dout_vld), 32'h1);
        chk("fix_o_data",  32'(dout),     32'hC0);
        tick();                                   // edge N+2: transfer counted
        chk("fix_o_cnt",   32'(cnt),      32'h1);
        chk("fix_drained", 32'(dout_vld), 32'h0);
        chk("fix_hold",    32'(dout),     32'hC0);

        // ---- Auto-increment with wrap ----
        mode = 1'b1; k_cfg = 3'd0; clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_o_cnt", 32'(cnt), 32'h0);
        exp_seq[0] = 8'h01; exp_seq[1] = 8'h80; exp_seq[2] = 8'h40;
        exp_seq[3] = 8'h20; exp_seq[4] = 8'h10; exp_seq[5] = 8'h08;
        exp_seq[6] = 8'h04; exp_seq[7] = 8'h02; exp_seq[8] = 8'h01;
        for (int i = 0; i <= 10; i++) begin
            din = 8'h01;
            din_vld = (i < 9);
            if (i < 9) begin
                #1 chk($sformatf("auto_rdy%0d", i), 32'(dut_rdy), 32'h1);
            end
            tick();
            if (i >= 1 && i <= 9) begin
                chk($sformatf("auto_vld%0d", i - 1), 32'(dout_vld), 32'h1);
                chk($sformatf("auto_dat%0d", i - 1), 32'(dout), 32'(exp_seq[i-1]));
            end
        end
        chk("auto_o_cnt", 32'(cnt), 32'd9);

        // ---- Backpressure ----
        mode = 1'b0; k_cfg = 3'd0; clear = 1'b1; din_vld = 1'b0;
        tick();
        clear = 1'b0; cons_rdy = 1'b0;
        din = 8'h10; din_vld = 1'b1;
        #1 chk("bp_rdy0", 32'(dut_rdy), 32'h1);
        tick();
        chk("bp_vld0", 32'(dout_vld), 32'h0);
        din = 8'h20;
        #1 chk("bp_rdy1", 32'(dut_rdy), 32'h1);
        tick();
        chk("bp_vld1", 32'(dout_vld), 32'h1);
        chk("bp_dat1", 32'(dout),     32'h10);
        din = 8'h30;
        #1 chk("bp_full_rdy", 32'(dut_rdy), 32'h0);
        tick();
        chk("bp_hold_dat", 32'(dout),     32'h10);
        chk("bp_hold_vld", 32'(dout_vld), 32'h1);
        chk("bp_hold_cnt", 32'(cnt),      32'h0);
        cons_rdy = 1'b1;
        #1 chk("bp_release_rdy", 32'(dut_rdy), 32'h1);
        tick();
        din_vld = 1'b0;
        chk("bp_out2", 32'(dout), 32'h20);
        chk("bp_cnt1", 32'(cnt),  32'h1);
        tick();
        chk("bp_out3", 32'(dout), 32'h30);
        chk("bp_cnt2", 32'(cnt),  32'h2);
        tick();
        chk("bp_empty", 32'(dout_vld), 32'h0);
        chk("bp_cnt3",  32'(cnt),      32'h3);

        // ---- Clear mid-stream with both stages full ----
        cons_rdy = 1'b0; mode = 1'b0; k_cfg = 3'd0;
        din = 8'hAA; din_vld = 1'b1;
        tick();
        din = 8'h55;
        tick();
        chk("cl_full_dat", 32'(dout),  32'hAA);
        chk("cl_full_s1",  32'(rot_a), 32'h55);
        cons_rdy = 1'b1; clear = 1'b1; mode = 1'b1; k_cfg = 3'd5;
        din = 8'h77; din_vld = 1'b1;
        #1 chk("cl_o_ready", 32'(dut_rdy), 32'h0);
        tick();
        chk("cl_o_valid", 32'(dout_vld), 32'h0);
        chk("cl_o_cnt",   32'(cnt),      32'h0);
        chk("cl_dat_hold", 32'(dout),    32'hAA);
        chk("cl_rot_hold", 32'(rot_a),   32'h55);
        clear = 1'b0; k_cfg = 3'd2; din = 8'h01; din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        chk("cl_k_reload", 32'(rot_k), 32'h5);
        chk("cl_next_a",   32'(rot_a), 32'h01);
        tick();
        chk("cl_next_vld", 32'(dout_vld), 32'h1);
        chk("cl_next_dat", 32'(dout),     32'h08);
        tick();
        chk("cl_no_extra", 32'(dout_vld), 32'h0);

        // ---- Reset mid-stream ----
        mode = 1'b1; din = 8'h03; din_vld = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1 chk("rr_o_ready", 32'(dut_rdy), 32'h0);
        tick();
        chk("rr_o_valid", 32'(dout_vld), 32'h0);
        chk("rr_o_data",  32'(dout),     32'h0);
        chk("rr_rot_a",   32'(rot_a),    32'h0);
        chk("rr_rot_k",   32'(rot_k),    32'h0);
        chk("rr_o_cnt",   32'(cnt),      32'h0);
        rst = 1'b0; k_cfg = 3'd3; din = 8'h02; din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        chk("rr_first_k", 32'(rot_k), 32'h0);
        tick();
        chk("rr_first_vld", 32'(dout_vld), 32'h1);
        chk("rr_first_dat", 32'(dout),     32'h02);

        // ---- Counter saturation on the CNT_W=4 instance ----
        mode = 1'b0; k_cfg = 3'd0; clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("sat_clr", 32'(cnt4), 32'h0);
        for (int i = 0; i < 20; i++) begin
            din = 8'(i); din_vld = 1'b1;
            tick();
        end
        din_vld = 1'b0;
        tick();
        tick();
        chk("sat_cnt4",  32'(cnt4), 32'd15);
        chk("sat_cnt16", 32'(cnt),  32'd20);
        din = 8'h5A; din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        tick();
        tick();
        chk("sat_held", 32'(cnt4), 32'd15);
        chk("sat_last", 32'(dout4), 32'h5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
